// File: rtl/lsu_mem_stage.sv
// Load/store unit memory stage: one outstanding req/gnt/rvalid transaction, aligned load return.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem_stage #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_t;

    state_t state_q, state_d;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic [AWIDTH-3:0] addr_hi_q;
    logic [3:0]        be_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              is_byte;
    logic              is_half;
    logic              misalign;
    logic [1:0]        off_n;
    logic [3:0]        be_n;
    logic [DWIDTH-1:0] wdata_n;
    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] ext;

    assign accept  = req_valid && (state_q == StIdle);
    assign is_byte = (req_size == 2'b00);
    assign is_half = (req_size == 2'b01);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (is_half && req_addr[0]) ||
                      (!is_byte && !is_half && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane offset drops address bits below natural alignment.
    always_comb begin
        off_n   = 2'b00;
        be_n    = 4'b1111;
        wdata_n = req_wdata;
        if (is_byte) begin
            off_n   = req_addr[1:0];
            be_n    = 4'b0001 << req_addr[1:0];
            wdata_n = {4{req_wdata[7:0]}};
        end else if (is_half) begin
            off_n   = {req_addr[1], 1'b0};
            be_n    = 4'b0011 << {req_addr[1], 1'b0};
            wdata_n = {2{req_wdata[15:0]}};
        end
    end

    assign shifted = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = shifted;
        unique case (size_q)
            2'b00: ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = misalign ? StResp : StReq;
            StReq:  if (mem_gnt) state_d = we_q ? StResp : StWait;
            StWait: if (mem_rvalid) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            addr_hi_q <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q      <= req_we;
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                off_q     <= off_n;
                addr_hi_q <= req_addr[AWIDTH-1:2];
                be_q      <= be_n;
                wdata_q   <= wdata_n;
                rdata_q   <= '0;
                err_q     <= misalign;
            end else if (state_q == StWait && mem_rvalid) begin
                rdata_q <= ext;
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign mem_req   = (state_q == StReq);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_hi_q, 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed vector table, random transactions, reset cases.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          gd;
        int          rd;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] mdata, input int gd, input int rd,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                                input logic e_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.mdata = mdata; v.gd = gd; v.rd = rd; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    // Reference: lane arithmetic straight from the access-size rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r = v;
        int unsigned lanes;
        int unsigned lo;
        int unsigned off;
        longint      val;
        lanes = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        lo    = v.addr % 4;
        off   = (lo / lanes) * lanes;
        r.e_err = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (lo % lanes != 0) r.e_err = 1'b1;
`endif
        r.e_addr = v.addr & 32'hFFFF_FFFC;
        r.e_be   = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + lanes) r.e_be[i] = 1'b1;
        if (lanes == 1)      r.e_wdata = (v.wdata & 32'hFF) * 32'h0101_0101;
        else if (lanes == 2) r.e_wdata = (v.wdata & 32'hFFFF) * 32'h0001_0001;
        else                 r.e_wdata = v.wdata;
        if (v.we || r.e_err) begin
            r.e_rdata = 32'h0;
        end else begin
            val = (longint'(v.mdata) >> (8 * off)) & ((longint'(1) << (8 * lanes)) - 1);
            if (!v.uns && lanes < 4 && val >= (longint'(1) << (8 * lanes - 1)))
                val = val - (longint'(1) << (8 * lanes));
            r.e_rdata = val[31:0];
        end
        return r;
    endfunction

    // Entered just after a falling edge; leaves just after the falling edge following RESP.
    task automatic do_txn(input vec_t v, input string tag);
        check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; req_we = $urandom % 2; req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (v.e_err) begin
            check({tag, " err_valid"}, {31'h0, rsp_valid}, 32'h1);
            check({tag, " err_flag"}, {31'h0, rsp_err}, 32'h1);
            check({tag, " err_rdata"}, rsp_rdata, 32'h0);
            check({tag, " err_no_req"}, {31'h0, mem_req}, 32'h0);
        end else begin
            for (int i = 0; i <= v.gd; i++) begin
                check({tag, " mem_req"}, {31'h0, mem_req}, 32'h1);
                check({tag, " mem_addr"}, mem_addr, v.e_addr);
                check({tag, " mem_be"}, {28'h0, mem_be}, {28'h0, v.e_be});
                check({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
                if (v.we) check({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
                check({tag, " req_busy"}, {31'h0, req_ready}, 32'h0);
                check({tag, " no_rsp_req"}, {31'h0, rsp_valid}, 32'h0);
                mem_gnt = (i == v.gd);
                mem_rvalid = 1'($urandom);
                mem_rdata = $urandom;
                @(posedge clk); @(negedge clk);
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!v.we) begin
                for (int i = 0; i <= v.rd; i++) begin
                    check({tag, " wait_no_req"}, {31'h0, mem_req}, 32'h0);
                    check({tag, " wait_busy"}, {31'h0, req_ready}, 32'h0);
                    check({tag, " wait_no_rsp"}, {31'h0, rsp_valid}, 32'h0);
                    mem_rvalid = (i == v.rd);
                    mem_rdata  = (i == v.rd) ? v.mdata : $urandom;
                    mem_gnt    = 1'($urandom);
                    @(posedge clk); @(negedge clk);
                end
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            check({tag, " rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
            check({tag, " rsp_err"}, {31'h0, rsp_err}, 32'h0);
            check({tag, " rsp_rdata"}, rsp_rdata, v.e_rdata);
            check({tag, " rsp_no_req"}, {31'h0, mem_req}, 32'h0);
        end
        @(posedge clk); @(negedge clk);
        check({tag, " rsp_pulse"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst mem_req", {31'h0, mem_req}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_be", {28'h0, mem_be}, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err", {31'h0, rsp_err}, 32'h0);

        tbl.push_back(mk(0, 2'b00, 0, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0,
                         32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 0));
        tbl.push_back(mk(0, 2'b00, 1, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0,
                         32'h1000, 4'b1000, 32'h0, 32'h0000_0080, 0));
        tbl.push_back(mk(1, 2'b01, 0, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 0,
                         32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0, 0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h3000, 32'hDEAD_BEEF, 32'h0, 3, 0,
                         32'h3000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h5002, 32'h0, 32'h8001_7FFF, 0, 5,
                         32'h5000, 4'b1100, 32'h0, 32'hFFFF_8001, 0));
        tbl.push_back(mk(1, 2'b00, 0, 32'h0001, 32'h0000_00A5, 32'h0, 1, 0,
                         32'h0000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h0100, 32'h0, 32'h1234_8001, 0, 2,
                         32'h0100, 4'b0011, 32'h0, 32'h0000_8001, 0));
        tbl.push_back(mk(0, 2'b11, 1, 32'h0204, 32'h0, 32'hCAFE_F00D, 2, 1,
                         32'h0204, 4'b1111, 32'h0, 32'hCAFE_F00D, 0));
`ifdef LSU_MISALIGN_CHECK_EN
        tbl.push_back(mk(0, 2'b10, 0, 32'h4001, 32'h0, 32'h1122_3344, 0, 0,
                         32'h4000, 4'b1111, 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 2'b01, 0, 32'h0103, 32'h0, 32'hF0E1_D2C3, 0, 0,
                         32'h0100, 4'b1100, 32'h0, 32'h0, 1));
`else
        tbl.push_back(mk(0, 2'b10, 0, 32'h4001, 32'h0, 32'h1122_3344, 0, 0,
                         32'h4000, 4'b1111, 32'h0, 32'h1122_3344, 0));
        tbl.push_back(mk(0, 2'b01, 0, 32'h0103, 32'h0, 32'hF0E1_D2C3, 0, 0,
                         32'h0100, 4'b1100, 32'h0, 32'hFFFF_F0E1, 0));
`endif
        foreach (tbl[i]) do_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for read data; the stale rvalid must be dropped.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h6000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; mem_gnt = 1'b1;
        check("rstwait mem_req", {31'h0, mem_req}, 32'h1);
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        check("rstwait in_wait", {31'h0, mem_req}, 32'h0);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rstwait ready", {31'h0, req_ready}, 32'h1);
        check("rstwait mem_req_off", {31'h0, mem_req}, 32'h0);
        check("rstwait no_rsp", {31'h0, rsp_valid}, 32'h0);
        check("rstwait mem_addr", mem_addr, 32'h0);
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstwait late_rvalid", {31'h0, rsp_valid}, 32'h0);
            check("rstwait idle", {31'h0, req_ready}, 32'h1);
            @(posedge clk); @(negedge clk);
        end

        // Reset during a stalled request.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h7000;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        check("rstreq mem_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("rstreq mem_req_off", {31'h0, mem_req}, 32'h0);
        check("rstreq mem_we", {31'h0, mem_we}, 32'h0);
        check("rstreq ready", {31'h0, req_ready}, 32'h1);

        for (int n = 0; n < 200; n++) begin
            vec_t v;
            v.we = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
            v.addr = $urandom; v.wdata = $urandom; v.mdata = $urandom;
            v.gd = $urandom_range(0, 3); v.rd = $urandom_range(0, 3);
            v = model(v);
            do_txn(v, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
